spin_update_ctrl: RTL and testbench
===================================

# spin_update_ctrl

Sequential spin-update controller on the other side of the local-energy datapath. It holds the spin vector, walks the spins one index at a time, issues a request for each spin's local energy and takes the returned signed energy. It flips the spin when that energy is below a threshold, then repeats full sweeps until a sweep makes no flip or a sweep limit is reached. It sits between the spin load/readout path and the partial-energy calculator: it drives that calculator's spin inputs and consumes its energy output through a valid/ready handshake.

## Interface
- DATASPIN, 256, number of spins
- LOCAL_ENERGY_BIT, 16, width of signed local energy
- SWEEP_BIT, 8, width of sweep limit and counter
- IDXW, $clog2(DATASPIN), spin index width
- NOISE_BIT, 4, width of threshold dither (used only with macro)

- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- spin_load_valid_i  in  1  initial spin vector valid
- spin_load_ready_o  out  1  high only in IDLE
- spin_load_i  in  DATASPIN  initial spins (1 = +1, 0 = -1)
- start_i  in  1  begin annealing (sampled in IDLE only)
- max_sweep_i  in  SWEEP_BIT  sweep limit, sampled at start; 0 treated as 1
- threshold_i  in  LOCAL_ENERGY_BIT signed  flip threshold, sampled at start
- eng_req_valid_o  out  1  energy request for spin idx_o
- eng_req_ready_i  in  1  calculator accepts request
- idx_o  out  IDXW  index under evaluation
- spin_o  out  DATASPIN  current spin register (always visible)
- current_spin_o  out  1  spin_o[idx_o]
- energy_valid_i  in  1  energy response valid
- energy_ready_o  out  1  high only in WAIT
- energy_i  in  LOCAL_ENERGY_BIT signed  local energy of spin idx_o
- busy_o  out  1  not IDLE
- done_o  out  1  one-cycle completion pulse
- converged_o  out  1  last run ended on a zero-flip sweep
- sweep_cnt_o  out  SWEEP_BIT  completed sweeps of last/current run
- flip_cnt_o  out  IDXW+SWEEP_BIT  total flips of last/current run

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: spin_load_ready_o=1. A load handshake writes spin_load_i into the spin register. When start_i=1 and no load occurs in the same cycle, the block captures threshold and limit, clears idx, sweep_cnt, flip_cnt, sweep-flip flag and converged_o, and moves to REQ. If load and start coincide, the load wins and start is ignored.
- REQ: eng_req_valid_o=1. When eng_req_ready_i=1 the block moves to WAIT. idx_o and spin_o stay stable while valid is high.
- WAIT: energy_ready_o=1. On energy_valid_i the block flips when energy_i < effective threshold. The comparison is signed and done at LOCAL_ENERGY_BIT+1 bits, so it cannot overflow.
- A flip inverts spin[idx], increments flip_cnt, which saturates at all-ones, and sets the sweep-flip flag.
- If idx < DATASPIN-1 after a response: idx increments and the block returns to REQ.
- If idx = DATASPIN-1 after a response: sweep_cnt increments.
  - If the sweep-flip flag (including this flip) is 0: converged_o=1 and the block goes to DONE.
  - Otherwise, if sweep_cnt+1 ≥ limit: the block goes to DONE with converged_o=0.
  - Otherwise: idx wraps to 0, the flag clears and the block returns to REQ.
- DONE: done_o=1 for exactly one cycle, then IDLE. Spin register, counters and converged_o hold until the next start.

## Timing
- Reset values: state IDLE, spin register 0, idx 0, all counters 0, every valid/ready/pulse output 0 except spin_load_ready_o=1, converged_o=0.
- Reset mid-run aborts immediately. There is no done pulse and spins return to 0.
- Spin update is visible on spin_o the cycle after the energy handshake.
- Minimum two cycles per spin (REQ, WAIT) when the calculator is always ready and valid. A run costs ≥2·DATASPIN·sweeps + 1 cycles.
- A response with energy_valid_i outside WAIT is ignored.

## Configuration
- SPIN_UPDATE_NOISE_EN defined:
  - A 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, seeds to 16'hACE1 at reset and steps on every accepted energy.
  - Effective threshold = threshold + sign-extended lfsr[NOISE_BIT-1:0], read as two's complement.
- Undefined: effective threshold = threshold exactly, and no LFSR flops exist.

## Structure
- Shared package spin_update_pkg holds:
  - state enum
  - LFSR seed and polynomial constants
  - the comparison-width helper constant
- One sub-module, spin_update_lfsr, instantiated only under SPIN_UPDATE_NOISE_EN.

## Test plan
All scenarios use DATASPIN=4, LOCAL_ENERGY_BIT=8, noise off unless stated.
- Load 4'b1010, start, threshold 0, calculator returns +5 for every spin -> 1 sweep, no flips, converged_o=1, sweep_cnt_o=1, spin_o=4'b1010, done_o pulses once.
- Load 4'b0000, threshold 0, energies -3 in sweep 1 and +3 afterwards -> spin_o=4'b1111, flip_cnt_o=4, sweep_cnt_o=2, converged_o=1.
- Energies always -1, max_sweep_i=3 -> spin_o toggles each sweep, done after 3 sweeps, converged_o=0, flip_cnt_o=12.
- eng_req_ready_i held low 5 cycles and energy_valid_i delayed 3 cycles -> idx_o and spin_o stable throughout, result identical to the zero-stall run.
- Reset asserted during WAIT of sweep 2 -> all outputs at reset values next edge, no done_o pulse.
- Noise on, threshold 0, energy 0 each spin -> flip decisions match a reference LFSR model seeded 16'hACE1.

Source files
------------

// File: rtl/spin_update_pkg.sv
// Shared types and constants for the spin-update controller.
// The optional threshold dither is enabled with SPIN_UPDATE_NOISE_EN.
package spin_update_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int unsigned LFSR_W = 16;

    // Galois taps for x^16+x^14+x^13+x^11+1, right-shifting form
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    localparam logic [LFSR_W-1:0] LFSR_POLY = 16'hB400;

    // One guard bit makes the signed energy/threshold compare overflow-free
    localparam int unsigned CMP_GUARD_BIT = 1;

endpackage

// File: rtl/spin_update_lfsr.sv
// 16-bit Galois LFSR supplying the low NOISE_BIT bits as threshold dither.
// Only instantiated when SPIN_UPDATE_NOISE_EN is defined.
module spin_update_lfsr
    import spin_update_pkg::*;
#(
    parameter int unsigned NOISE_BIT = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 step_i,
    output logic [NOISE_BIT-1:0] noise_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (step_i) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_POLY : '0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign noise_o = lfsr_q[NOISE_BIT-1:0];

endmodule

// File: rtl/spin_update_ctrl.sv
// Sequential spin-update controller: sweeps spins, requests local energies and
// flips spins below threshold. SPIN_UPDATE_NOISE_EN adds LFSR threshold dither.
module spin_update_ctrl
    import spin_update_pkg::*;
#(
    parameter int unsigned DATASPIN         = 256,
    parameter int unsigned LOCAL_ENERGY_BIT = 16,
    parameter int unsigned SWEEP_BIT        = 8,
    parameter int unsigned IDXW             = $clog2(DATASPIN),
    parameter int unsigned NOISE_BIT        = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          spin_load_valid_i,
    output logic                          spin_load_ready_o,
    input  logic [DATASPIN-1:0]           spin_load_i,
    input  logic                          start_i,
    input  logic [SWEEP_BIT-1:0]          max_sweep_i,
    input  logic [LOCAL_ENERGY_BIT-1:0]   threshold_i,
    output logic                          eng_req_valid_o,
    input  logic                          eng_req_ready_i,
    output logic [IDXW-1:0]               idx_o,
    output logic [DATASPIN-1:0]           spin_o,
    output logic                          current_spin_o,
    input  logic                          energy_valid_i,
    output logic                          energy_ready_o,
    input  logic [LOCAL_ENERGY_BIT-1:0]   energy_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          converged_o,
    output logic [SWEEP_BIT-1:0]          sweep_cnt_o,
    output logic [IDXW+SWEEP_BIT-1:0]     flip_cnt_o
);

    localparam int unsigned CMPW = LOCAL_ENERGY_BIT + CMP_GUARD_BIT;
    localparam int unsigned FCW  = IDXW + SWEEP_BIT;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(DATASPIN - 1);

    state_e                        state_q, state_d;
    logic [DATASPIN-1:0]           spin_q, spin_d;
    logic [IDXW-1:0]               idx_q, idx_d;
    logic [SWEEP_BIT-1:0]          sweep_cnt_q, sweep_cnt_d;
    logic [SWEEP_BIT-1:0]          limit_q, limit_d;
    logic [LOCAL_ENERGY_BIT-1:0]   thr_q, thr_d;
    logic [FCW-1:0]                flip_cnt_q, flip_cnt_d;
    logic                          sweep_flip_q, sweep_flip_d;
    logic                          converged_q, converged_d;

    logic [NOISE_BIT-1:0]          noise;
    logic                          energy_fire;
    logic signed [CMPW-1:0]        energy_ext;
    logic signed [CMPW-1:0]        thr_eff;
    logic                          do_flip;
    logic                          sweep_flag_now;
    logic [SWEEP_BIT-1:0]          sweep_nxt;

    assign energy_fire = (state_q == ST_WAIT) && energy_valid_i;

`ifdef SPIN_UPDATE_NOISE_EN
    spin_update_lfsr #(
        .NOISE_BIT (NOISE_BIT)
    ) u_lfsr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .step_i  (energy_fire),
        .noise_o (noise)
    );
`else
    assign noise = '0;
`endif

    // Sign-extend both operands one bit so threshold+dither cannot wrap
    assign energy_ext = {{CMP_GUARD_BIT{energy_i[LOCAL_ENERGY_BIT-1]}}, energy_i};
    assign thr_eff    = {{CMP_GUARD_BIT{thr_q[LOCAL_ENERGY_BIT-1]}}, thr_q}
                      + {{(CMPW-NOISE_BIT){noise[NOISE_BIT-1]}}, noise};

    assign do_flip        = energy_fire && (energy_ext < thr_eff);
    assign sweep_flag_now = sweep_flip_q | do_flip;
    assign sweep_nxt      = sweep_cnt_q + SWEEP_BIT'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            spin_q       <= '0;
            idx_q        <= '0;
            sweep_cnt_q  <= '0;
            limit_q      <= '0;
            thr_q        <= '0;
            flip_cnt_q   <= '0;
            sweep_flip_q <= 1'b0;
            converged_q  <= 1'b0;
        end else begin
            spin_q       <= spin_d;
            idx_q        <= idx_d;
            sweep_cnt_q  <= sweep_cnt_d;
            limit_q      <= limit_d;
            thr_q        <= thr_d;
            flip_cnt_q   <= flip_cnt_d;
            sweep_flip_q <= sweep_flip_d;
            converged_q  <= converged_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        spin_d       = spin_q;
        idx_d        = idx_q;
        sweep_cnt_d  = sweep_cnt_q;
        limit_d      = limit_q;
        thr_d        = thr_q;
        flip_cnt_d   = flip_cnt_q;
        sweep_flip_d = sweep_flip_q;
        converged_d  = converged_q;

        unique case (state_q)
            ST_IDLE: begin
                // A load in the same cycle as start takes priority
                if (spin_load_valid_i) begin
                    spin_d = spin_load_i;
                end else if (start_i) begin
                    thr_d        = threshold_i;
                    limit_d      = (max_sweep_i == '0) ? SWEEP_BIT'(1) : max_sweep_i;
                    idx_d        = '0;
                    sweep_cnt_d  = '0;
                    flip_cnt_d   = '0;
                    sweep_flip_d = 1'b0;
                    converged_d  = 1'b0;
                    state_d      = ST_REQ;
                end
            end
            ST_REQ: begin
                if (eng_req_ready_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (energy_valid_i) begin
                    if (do_flip) begin
                        spin_d[idx_q] = ~spin_q[idx_q];
                        sweep_flip_d  = 1'b1;
                        if (flip_cnt_q != '1) begin
                            flip_cnt_d = flip_cnt_q + FCW'(1);
                        end
                    end
                    if (idx_q != IDX_LAST) begin
                        idx_d   = idx_q + IDXW'(1);
                        state_d = ST_REQ;
                    end else begin
                        sweep_cnt_d = sweep_nxt;
                        if (!sweep_flag_now) begin
                            converged_d = 1'b1;
                            state_d     = ST_DONE;
                        end else if (sweep_nxt >= limit_q) begin
                            state_d = ST_DONE;
                        end else begin
                            idx_d        = '0;
                            sweep_flip_d = 1'b0;
                            state_d      = ST_REQ;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        spin_load_ready_o = 1'b0;
        eng_req_valid_o   = 1'b0;
        energy_ready_o    = 1'b0;
        busy_o            = 1'b1;
        done_o            = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                spin_load_ready_o = 1'b1;
                busy_o            = 1'b0;
            end
            ST_REQ:  eng_req_valid_o = 1'b1;
            ST_WAIT: energy_ready_o  = 1'b1;
            ST_DONE: done_o          = 1'b1;
            default: busy_o          = 1'b1;
        endcase
    end

    assign idx_o          = idx_q;
    assign spin_o         = spin_q;
    assign current_spin_o = spin_q[idx_q];
    assign converged_o    = converged_q;
    assign sweep_cnt_o    = sweep_cnt_q;
    assign flip_cnt_o     = flip_cnt_q;

endmodule

// File: tb/tb_spin_update_ctrl.sv
// Directed bench for spin_update_ctrl (DATASPIN=4, LOCAL_ENERGY_BIT=8) with a
// spin-state scoreboard; the dither scenario runs when SPIN_UPDATE_NOISE_EN is defined.
module tb_spin_update_ctrl;

    localparam int unsigned N  = 4;
    localparam int unsigned EB = 8;
    localparam int unsigned SB = 8;
    localparam int unsigned IW = 2;
    localparam int unsigned NB = 4;
    localparam int unsigned FW = IW + SB;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          spin_load_valid_i = 1'b0;
    logic          spin_load_ready_o;
    logic [N-1:0]  spin_load_i = '0;
    logic          start_i = 1'b0;
    logic [SB-1:0] max_sweep_i = '0;
    logic [EB-1:0] threshold_i = '0;
    logic          eng_req_valid_o;
    logic          eng_req_ready_i = 1'b0;
    logic [IW-1:0] idx_o;
    logic [N-1:0]  spin_o;
    logic          current_spin_o;
    logic          energy_valid_i = 1'b0;
    logic          energy_ready_o;
    logic [EB-1:0] energy_i = '0;
    logic          busy_o;
    logic          done_o;
    logic          converged_o;
    logic [SB-1:0] sweep_cnt_o;
    logic [FW-1:0] flip_cnt_o;

    int total = 0;
    int bad   = 0;
    logic [N-1:0] exp_q[$];
`ifdef SPIN_UPDATE_NOISE_EN
    logic [15:0] m_lfsr = 16'hACE1;
`endif

    always #5 clk_i = ~clk_i;

    spin_update_ctrl #(
        .DATASPIN (N), .LOCAL_ENERGY_BIT (EB), .SWEEP_BIT (SB), .IDXW (IW), .NOISE_BIT (NB)
    ) dut (
        .clk_i (clk_i), .rst_ni (rst_ni),
        .spin_load_valid_i (spin_load_valid_i), .spin_load_ready_o (spin_load_ready_o),
        .spin_load_i (spin_load_i), .start_i (start_i),
        .max_sweep_i (max_sweep_i), .threshold_i (threshold_i),
        .eng_req_valid_o (eng_req_valid_o), .eng_req_ready_i (eng_req_ready_i),
        .idx_o (idx_o), .spin_o (spin_o), .current_spin_o (current_spin_o),
        .energy_valid_i (energy_valid_i), .energy_ready_o (energy_ready_o),
        .energy_i (energy_i), .busy_o (busy_o), .done_o (done_o),
        .converged_o (converged_o), .sweep_cnt_o (sweep_cnt_o), .flip_cnt_o (flip_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_checks(input string nm);
        chk({nm, ".load_ready"}, 32'(spin_load_ready_o), 32'd1);
        chk({nm, ".req_valid"},  32'(eng_req_valid_o), 32'd0);
        chk({nm, ".eng_ready"},  32'(energy_ready_o), 32'd0);
        chk({nm, ".busy"},       32'(busy_o), 32'd0);
        chk({nm, ".done"},       32'(done_o), 32'd0);
        chk({nm, ".converged"},  32'(converged_o), 32'd0);
        chk({nm, ".sweep_cnt"},  32'(sweep_cnt_o), 32'd0);
        chk({nm, ".flip_cnt"},   32'(flip_cnt_o), 32'd0);
        chk({nm, ".spin"},       32'(spin_o), 32'd0);
        chk({nm, ".idx"},        32'(idx_o), 32'd0);
    endtask

    // Loads, starts and services one annealing run while modelling every flip.
    task automatic run(input string nm, input logic [N-1:0] load, input int thr, input int maxsw,
                       input int e_first, input int e_rest, input int req_stall, input int rsp_stall,
                       input int abort_sweep, input logic [N-1:0] h_spin, input logic h_conv,
                       input int h_sweep, input int h_flips);
        logic [N-1:0] m_spin = load;
        int  m_idx = 0, m_sweep = 0, m_flips = 0, lim, e, nz;
        int  stall_r = req_stall, stall_e = rsp_stall;
        bit  m_sflag = 0, m_conv = 0, done_due = 0, finished = 0, pend = 0, flip;
        logic [N-1:0] exp_spin;
        lim = (maxsw == 0) ? 1 : maxsw;

        spin_load_valid_i = 1'b1;
        spin_load_i = load;
        @(posedge clk_i); #1;
        spin_load_valid_i = 1'b0;
        chk({nm, ".loaded"}, 32'(spin_o), 32'(load));
        start_i = 1'b1;
        threshold_i = EB'(thr);
        max_sweep_i = SB'(maxsw);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        chk({nm, ".busy_start"}, 32'(busy_o), 32'd1);
        chk({nm, ".conv_cleared"}, 32'(converged_o), 32'd0);
        chk({nm, ".flips_cleared"}, 32'(flip_cnt_o), 32'd0);

        for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
            if (pend) begin
                exp_spin = exp_q.pop_front();
                chk({nm, ".spin_upd"}, 32'(spin_o), 32'(exp_spin));
                pend = 0;
            end
            chk({nm, ".done_timing"}, 32'(done_o), 32'(done_due));
            eng_req_ready_i = 1'b0;
            energy_valid_i  = 1'b0;
            if (done_due) begin
                chk({nm, ".m_conv"},  32'(converged_o), 32'(m_conv));
                chk({nm, ".m_sweep"}, 32'(sweep_cnt_o), 32'(m_sweep));
                chk({nm, ".m_flips"}, 32'(flip_cnt_o), 32'(m_flips));
`ifndef SPIN_UPDATE_NOISE_EN
                chk({nm, ".spin_final"}, 32'(spin_o), 32'(h_spin));
                chk({nm, ".conv_final"}, 32'(converged_o), 32'(h_conv));
                chk({nm, ".sweep_final"}, 32'(sweep_cnt_o), 32'(h_sweep));
                chk({nm, ".flips_final"}, 32'(flip_cnt_o), 32'(h_flips));
`endif
                finished = 1;
            end else if (abort_sweep >= 0 && energy_ready_o && m_sweep == abort_sweep) begin
                rst_ni = 1'b0;
                #1;
                reset_checks({nm, ".abort_async"});
                @(posedge clk_i); #1;
                reset_checks({nm, ".abort_edge"});
                rst_ni = 1'b1;
                exp_q.delete();
`ifdef SPIN_UPDATE_NOISE_EN
                m_lfsr = 16'hACE1;
`endif
                finished = 1;
            end else begin
                if (eng_req_valid_o) begin
                    chk({nm, ".req_idx"},  32'(idx_o), 32'(m_idx));
                    chk({nm, ".req_spin"}, 32'(spin_o), 32'(m_spin));
                    chk({nm, ".cur_spin"}, 32'(current_spin_o), 32'(m_spin[m_idx]));
                    // A stray response outside WAIT must be ignored
                    energy_valid_i = 1'b1;
                    energy_i = 8'h80;
                    if (stall_r > 0) stall_r--;
                    else begin
                        eng_req_ready_i = 1'b1;
                        stall_r = req_stall;
                    end
                end
                if (energy_ready_o) begin
                    chk({nm, ".wait_idx"},  32'(idx_o), 32'(m_idx));
                    chk({nm, ".wait_spin"}, 32'(spin_o), 32'(m_spin));
                    if (stall_e > 0) stall_e--;
                    else begin
                        stall_e = rsp_stall;
                        e = (m_sweep == 0) ? e_first : e_rest;
                        energy_valid_i = 1'b1;
                        energy_i = EB'(e);
                        nz = 0;
`ifdef SPIN_UPDATE_NOISE_EN
                        nz = m_lfsr[3] ? int'(m_lfsr[3:0]) - 16 : int'(m_lfsr[3:0]);
                        m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
`endif
                        flip = (e < thr + nz);
                        if (flip) begin
                            m_spin[m_idx] = ~m_spin[m_idx];
                            m_flips++;
                            m_sflag = 1;
                        end
                        exp_q.push_back(m_spin);
                        pend = 1;
                        if (m_idx == N - 1) begin
                            m_sweep++;
                            if (!m_sflag) begin
                                m_conv = 1;
                                done_due = 1;
                            end else if (m_sweep >= lim) begin
                                done_due = 1;
                            end else begin
                                m_idx = 0;
                                m_sflag = 0;
                            end
                        end else begin
                            m_idx++;
                        end
                    end
                end
                @(posedge clk_i); #1;
            end
        end
        eng_req_ready_i = 1'b0;
        energy_valid_i  = 1'b0;
        chk({nm, ".run_end"}, 32'(finished), 32'd1);
        if (abort_sweep < 0) begin
            @(posedge clk_i); #1;
            chk({nm, ".done_once"}, 32'(done_o), 32'd0);
            chk({nm, ".idle_ready"}, 32'(spin_load_ready_o), 32'd1);
            chk({nm, ".spin_hold"}, 32'(spin_o), 32'(m_spin));
            chk({nm, ".conv_hold"}, 32'(converged_o), 32'(m_conv));
        end
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        reset_checks("reset");
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

`ifndef SPIN_UPDATE_NOISE_EN
        run("no_flip",    4'b1010, 0, 8, 5, 5, 0, 0, -1, 4'b1010, 1'b1, 1, 0);
        run("one_sweep",  4'b0000, 0, 8, -3, 3, 0, 0, -1, 4'b1111, 1'b1, 2, 4);
        run("limit3",     4'b0101, 0, 3, -1, -1, 0, 0, -1, 4'b1010, 1'b0, 3, 12);
        run("stalled",    4'b0000, 0, 8, -3, 3, 5, 3, -1, 4'b1111, 1'b1, 2, 4);
        run("limit0",     4'b0000, 0, 0, -1, -1, 0, 0, -1, 4'b1111, 1'b0, 1, 4);
        run("eq_thr",     4'b1001, -4, 8, -4, -4, 0, 0, -1, 4'b1001, 1'b1, 1, 0);
        run("max_thr",    4'b0011, 127, 2, -128, -128, 0, 0, -1, 4'b0011, 1'b0, 2, 8);
        run("min_thr",    4'b0011, -128, 8, 127, 127, 0, 0, -1, 4'b0011, 1'b1, 1, 0);
        run("abort",      4'b0101, 0, 3, -1, -1, 0, 0, 1, 4'b0000, 1'b0, 0, 0);
        run("after_rst",  4'b0110, 0, 8, 5, 5, 0, 0, -1, 4'b0110, 1'b1, 1, 0);

        // Load and start in the same cycle: load wins, start is dropped
        spin_load_valid_i = 1'b1;
        spin_load_i = 4'b0110;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        spin_load_valid_i = 1'b0;
        start_i = 1'b0;
        chk("coincide.busy", 32'(busy_o), 32'd0);
        chk("coincide.spin", 32'(spin_o), 32'h6);
        @(posedge clk_i); #1;
        chk("coincide.idle", 32'(spin_load_ready_o), 32'd1);
`else
        run("noise",      4'b0000, 0, 4, 0, 0, 0, 0, -1, 4'b0000, 1'b0, 0, 0);
        run("noise2",     4'b1111, 0, 6, 0, 0, 2, 1, -1, 4'b0000, 1'b0, 0, 0);
        run("noise_rst",  4'b0101, 0, 3, -1, -1, 0, 0, 1, 4'b0000, 1'b0, 0, 0);
        run("noise3",     4'b0110, 0, 5, 0, 0, 0, 0, -1, 4'b0000, 1'b0, 0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
